// File: rtl/uart_tx_cfg.sv
// UART transmitter with valid/ready input and a frame format fixed by parameters
// (data width, parity, stop bits); bit period derived from clock and baud rate.
module uart_tx_cfg #(
  parameter int BAUD      = 115200,
  parameter int F         = 50000000,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] data,
  input  logic                 valid,
  output logic                 ready,
  output logic                 tx,
  output logic                 busy
);

  localparam int DIV = (F + BAUD / 2) / BAUD;
  localparam int TW  = (DIV > 2) ? $clog2(DIV) : 1;
  localparam int BCW = $clog2(DATA_BITS + 1);

  generate
    if (DIV < 2) begin : g_bad_div
      $error("uart_tx_cfg: clocks per bit must be at least 2");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_bits
      $error("uart_tx_cfg: DATA_BITS must be 5..9");
    end
    if (PARITY < 0 || PARITY > 2) begin : g_bad_par
      $error("uart_tx_cfg: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
      $error("uart_tx_cfg: STOP_BITS must be 1 or 2");
    end
  endgenerate

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP} state_t;

  state_t               state, state_n;
  logic [TW-1:0]        timer, timer_n;
  logic [BCW-1:0]       bit_cnt, bit_cnt_n;
  logic                 stop_cnt, stop_cnt_n;
  logic [DATA_BITS-1:0] shift, shift_n;
  logic                 par_bit, par_n;
  logic                 tx_n;
  logic                 bit_end;

  assign bit_end = (timer == TW'(DIV - 1));
  assign ready   = (state == S_IDLE);
  assign busy    = !ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      timer    <= '0;
      bit_cnt  <= '0;
      stop_cnt <= 1'b0;
      shift    <= '0;
      par_bit  <= 1'b0;
      tx       <= 1'b1;
    end else begin
      state    <= state_n;
      timer    <= timer_n;
      bit_cnt  <= bit_cnt_n;
      stop_cnt <= stop_cnt_n;
      shift    <= shift_n;
      par_bit  <= par_n;
      tx       <= tx_n;
    end
  end

  // tx_n is the line level for the next cycle, so tx is always a clean register output
  always_comb begin
    state_n    = state;
    timer_n    = timer;
    bit_cnt_n  = bit_cnt;
    stop_cnt_n = stop_cnt;
    shift_n    = shift;
    par_n      = par_bit;
    tx_n       = tx;

    if (state != S_IDLE) begin
      timer_n = bit_end ? '0 : timer + 1'b1;
    end

    case (state)
      S_IDLE: begin
        tx_n = 1'b1;
        if (valid) begin
          state_n = S_START;
          shift_n = data;
          par_n   = (PARITY == 1) ? ~(^data) : (^data);
          timer_n = '0;
          tx_n    = 1'b0;
        end
      end
      S_START: begin
        if (bit_end) begin
          state_n = S_DATA;
          tx_n    = shift[0];
        end
      end
      S_DATA: begin
        if (bit_end) begin
          shift_n = shift >> 1;
          if (bit_cnt == BCW'(DATA_BITS - 1)) begin
            bit_cnt_n = '0;
            if (PARITY != 0) begin
              state_n = S_PAR;
              tx_n    = par_bit;
            end else begin
              state_n = S_STOP;
              tx_n    = 1'b1;
            end
          end else begin
            bit_cnt_n = bit_cnt + 1'b1;
            tx_n      = shift[1];
          end
        end
      end
      S_PAR: begin
        if (bit_end) begin
          state_n = S_STOP;
          tx_n    = 1'b1;
        end
      end
      S_STOP: begin
        tx_n = 1'b1;
        if (bit_end) begin
          if (stop_cnt == 1'(STOP_BITS - 1)) begin
            state_n    = S_IDLE;
            stop_cnt_n = 1'b0;
          end else begin
            stop_cnt_n = stop_cnt + 1'b1;
          end
        end
      end
      default: begin
        state_n = S_IDLE;
        tx_n    = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Directed bench: four transmitter instances (8N1, 8E1, 8O1, 7N2) at 8 clocks
// per bit, each frame compared bit-by-bit against hand-written line sequences.
module tb_uart_tx_cfg;

  logic       clk;
  logic       rst;
  logic [8:0] data_v [4];
  logic [3:0] valid_v;
  wire  [3:0] tx_v;
  wire  [3:0] ready_v;
  wire  [3:0] busy_v;

  int checkCount;
  int failCount;
  longint hsTime;
  longint firstHs;

  uart_tx_cfg #(.BAUD(1), .F(8), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) dut8n1 (
    .clk(clk), .rst(rst), .data(data_v[0][7:0]), .valid(valid_v[0]),
    .ready(ready_v[0]), .tx(tx_v[0]), .busy(busy_v[0]));

  uart_tx_cfg #(.BAUD(1), .F(8), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) dut8e1 (
    .clk(clk), .rst(rst), .data(data_v[1][7:0]), .valid(valid_v[1]),
    .ready(ready_v[1]), .tx(tx_v[1]), .busy(busy_v[1]));

  uart_tx_cfg #(.BAUD(1), .F(8), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) dut8o1 (
    .clk(clk), .rst(rst), .data(data_v[2][7:0]), .valid(valid_v[2]),
    .ready(ready_v[2]), .tx(tx_v[2]), .busy(busy_v[2]));

  uart_tx_cfg #(.BAUD(1), .F(8), .DATA_BITS(7), .PARITY(0), .STOP_BITS(2)) dut7n2 (
    .clk(clk), .rst(rst), .data(data_v[3][6:0]), .valid(valid_v[3]),
    .ready(ready_v[3]), .tx(tx_v[3]), .busy(busy_v[3]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checkCount++;
    if (got !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Mode 0: plain frame; 1: keep valid high and load nextWord for a back-to-back frame;
  // 2: disturb data/valid mid-frame. seq is the line in transmit order, first bit leftmost.
  task automatic applyStimulus(input int idx, input logic [8:0] word, input logic [11:0] seq,
                               input int len, input int mode, input logic [8:0] nextWord);
    int fd;
    fd = len * 8;
    data_v[idx]  = word;
    valid_v[idx] = 1'b1;
    checkOutput("ready_before_hs", ready_v[idx], 1);
    @(posedge clk);
    hsTime = $time;
    for (int k = 0; k < fd; k++) begin
      @(negedge clk);
      if (k == 0 && mode != 1) valid_v[idx] = 1'b0;
      if (mode == 1 && k == fd / 2) data_v[idx] = nextWord;
      if (mode == 2 && k == 20) begin
        data_v[idx]  = ~word;
        valid_v[idx] = 1'b1;
      end
      if (mode == 2 && k == fd - 10) valid_v[idx] = 1'b0;
      checkOutput("tx_bit", tx_v[idx], seq[len - 1 - k / 8]);
      checkOutput("ready_in_frame", ready_v[idx], 0);
      checkOutput("busy_in_frame", busy_v[idx], 1);
    end
    @(negedge clk);
    checkOutput("ready_after_frame", ready_v[idx], 1);
    checkOutput("tx_idle_after_frame", tx_v[idx], 1);
    if (mode == 2) begin
      repeat (3) begin
        @(negedge clk);
        checkOutput("no_extra_hs_ready", ready_v[idx], 1);
        checkOutput("no_extra_hs_tx", tx_v[idx], 1);
      end
    end
  endtask

  initial begin
    checkCount = 0;
    failCount  = 0;
    hsTime     = 0;
    firstHs    = 0;
    valid_v    = 4'b0000;
    for (int i = 0; i < 4; i++) data_v[i] = 9'h000;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("reset_tx", tx_v, 4'hF);
    checkOutput("reset_ready", ready_v, 4'hF);
    checkOutput("reset_busy", busy_v, 4'h0);
    rst = 1'b0;
    @(negedge clk);

    // 8N1 0x55
    applyStimulus(0, 9'h055, 12'b00_0_10101010_1, 10, 0, 9'h000);
    // 8E1 and 8O1 with 0x07: only the parity bit differs
    applyStimulus(1, 9'h007, 12'b0_0_11100000_1_1, 11, 0, 9'h000);
    applyStimulus(2, 9'h007, 12'b0_0_11100000_0_1, 11, 0, 9'h000);
    // 7N2 0x41 with input bit 7 set
    applyStimulus(3, 9'h0C1, 12'b00_0_1000001_1_1, 10, 0, 9'h000);

    // back-to-back 0xA5 then 0x3C with valid held high
    applyStimulus(0, 9'h0A5, 12'b00_0_10100101_1, 10, 1, 9'h03C);
    firstHs = hsTime;
    applyStimulus(0, 9'h03C, 12'b00_0_00111100_1, 10, 0, 9'h000);
    checkOutput("b2b_start_spacing", 32'((hsTime - firstHs) / 10), 81);

    // mid-frame data change and valid toggle
    applyStimulus(0, 9'h096, 12'b00_0_01101001_1, 10, 2, 9'h000);

    // reset in the middle of data bit 3 of an all-zero frame
    data_v[0]  = 9'h000;
    valid_v[0] = 1'b1;
    @(posedge clk);
    for (int k = 0; k < 36; k++) begin
      @(negedge clk);
      if (k == 0) valid_v[0] = 1'b0;
    end
    checkOutput("pre_reset_tx_low", tx_v[0], 0);
    checkOutput("pre_reset_busy", busy_v[0], 1);
    rst = 1'b1;
    #1;
    checkOutput("async_reset_tx", tx_v[0], 1);
    checkOutput("async_reset_ready", ready_v[0], 1);
    checkOutput("async_reset_busy", busy_v[0], 0);
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(0, 9'h0FF, 12'b00_0_11111111_1, 10, 0, 9'h000);

    $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
    $finish;
  end

endmodule

// File: doc/uart_tx_cfg.md
# uart_tx_cfg

Parametrised UART transmitter with a valid/ready input handshake and configurable frame format. It serialises one word per handshake as start bit, data LSB-first, optional parity bit and one or two stop bits, at a bit period derived from the clock frequency and baud rate. It sits between a byte or word producer (command FSM, FIFO read side) and the board TX pin, and replaces the fixed 8N1 transmitter wherever flow control or another frame format is needed.

## Interface

Parameters:
- `BAUD`, 115200: line bit rate in bit/s.
- `F`, 50000000: `clk` frequency in Hz.
- `DATA_BITS`, 8: data bits per frame, legal range 5..9.
- `PARITY`, 0: 0 = none, 1 = odd, 2 = even.
- `STOP_BITS`, 1: 1 or 2.
- Derived `DIV` = (F + BAUD/2) / BAUD, clocks per bit, rounded to nearest. DIV < 2 or any illegal parameter is an elaboration error.

Ports:
- `clk`, in, 1: single clock.
- `rst`, in, 1: asynchronous, active-high reset.
- `data`, in, DATA_BITS: word to send; sampled only on the handshake.
- `valid`, in, 1: producer has a word.
- `ready`, out, 1: block accepts a word this cycle.
- `tx`, out, 1: serial line, idle high.
- `busy`, out, 1: frame in progress; equals !ready.

## Operation

- A handshake occurs on the rising `clk` edge where `valid && ready`. At that edge `data` is latched into a shift register, parity is computed from the latched word, and the state moves IDLE→START.
- States:
  - IDLE: `tx`=1, `ready`=1.
  - START: `tx`=0.
  - DATA: `tx`=current LSB of the shift register, shift right once per bit.
  - PARITY: only when PARITY≠0. Odd parity makes the count of ones over data plus parity odd; even parity makes it even.
  - STOP: `tx`=1 for STOP_BITS bit periods.
  - Return to IDLE.
- Bit timer counts 0..DIV-1 and resets to 0 at each state or bit change. A bit ends when the timer reaches DIV-1.
- A data bit counter of width clog2(DATA_BITS+1) counts sent data bits. DATA→PARITY or STOP happens after bit DATA_BITS-1. A stop counter handles STOP_BITS=2.
- `data` and `valid` are ignored outside IDLE. Changes to `data` mid-frame do not affect the frame.
- `tx` is driven from a register and is glitch-free. `ready` and `busy` are decoded from the state register.

## Timing

- Reset values: `tx`=1, `ready`=1, `busy`=0, state=IDLE, counters=0. Asserting `rst` mid-frame forces `tx` high immediately (asynchronously) and discards the frame. After release the block is in IDLE on the first edge.
- Latency: `tx` falls on the same edge as the handshake; the start bit is visible from the following cycle.
- Each bit lasts exactly DIV clocks.
- FRAME = 1 + DATA_BITS + (PARITY≠0) + STOP_BITS bits.
- `ready` returns to 1 on the edge ending the last stop bit, FRAME·DIV clocks after the handshake.
- Back-to-back: with `valid` held high, the next handshake happens in the first IDLE cycle. The idle-high gap between frames is exactly 1 clock, so the frame period is FRAME·DIV+1 clocks.
- `valid` asserted while busy is held off with no loss. The word present in the first IDLE cycle is sent.
- No internal buffering: at most one word in flight.

## Test plan

1. F=8, BAUD=1 (DIV=8), 8N1, send 0x55: `tx` is 0,1,0,1,0,1,0,1,0,1, each for 8 clocks. `ready` is 0 for 80 clocks, then returns to 1.
2. 8E1, send 0x07: data bits 1,1,1,0,0,0,0,0 and parity 1. Same word with 8O1: parity 0. The frame is 11 bits (88 clocks).
3. DATA_BITS=7, STOP_BITS=2, no parity, send 0x41: 7 data bits 1,0,0,0,0,0,1, then `tx` high for 16 clocks. `ready` returns after 80 clocks, and bit 7 of the input is ignored.
4. 8N1, `valid` held high with 0xA5 then 0x3C: two correct frames. The second start bit's falling edge is exactly 81 clocks after the first.
5. Change `data` and toggle `valid` mid-frame: the transmitted word is unchanged and no extra handshake occurs.
6. Assert `rst` during bit 3 of a frame: `tx`=1 and `ready`=1 immediately. A new 0xFF handshake after release produces a clean full frame.
